// File: rtl/snoop_bus_initiator.sv
// Snoop bus initiator: drives one coherent op on the shared bus, samples the snoop reply.
// Define SNOOP_WB_TIMEOUT_EN to add a watchdog that aborts a stalled HITM writeback.
module snoop_bus_initiator #(
    parameter int lineSize  = 512,
    parameter int addrWidth = 32,
    parameter int snoopWait = 2,
    parameter int wbTimeout = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic [7:0]           reqOp,
    input  logic [addrWidth-1:0] reqAddr,
    output logic [lineSize-1:0]  sharedBusOut,
    output logic [7:0]           sharedOperationBusOut,
    input  logic [1:0]           snoopBusIn,
    input  logic                 wbDone,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [1:0]           respResult,
    output logic [1:0]           respMesi,
    output logic                 respError
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] ISSUE      = 3'd1;
    localparam logic [2:0] SNOOP_WAIT = 3'd2;
    localparam logic [2:0] WB_WAIT    = 3'd3;
    localparam logic [2:0] RESP       = 3'd4;

    localparam logic [7:0] OP_READ  = 8'd1;
    localparam logic [7:0] OP_WRITE = 8'd2;
    localparam logic [7:0] OP_INV   = 8'd3;
    localparam logic [7:0] OP_RWIM  = 8'd4;

    localparam logic [1:0] SNP_HIT  = 2'b01;
    localparam logic [1:0] SNP_HITM = 2'b10;
    localparam logic [1:0] SNP_BAD  = 2'b11;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    if (snoopWait < 1 || snoopWait > 15) begin : gBadWait
        $error("snoopWait must lie in 1..15");
    end
    if (wbTimeout < 1) begin : gBadTimeout
        $error("wbTimeout must be at least 1");
    end
    if (lineSize < addrWidth) begin : gBadLine
        $error("lineSize must hold a full address");
    end

    logic [2:0]           state;
    logic [7:0]           opReg;
    logic [addrWidth-1:0] addrReg;
    logic [3:0]           waitCnt;
    logic [1:0]           resultReg;
    logic [1:0]           mesiReg;

    logic busOwned;
    logic accept;
    logic opLegal;
    logic isRead;
    logic isWrite;
    logic isInv;
    logic isRwim;
    logic sampleNow;
    logic goWb;
    logic [1:0] sampleMesi;

    assign accept  = (state == IDLE) && reqValid;
    assign opLegal = (reqOp == OP_READ) || (reqOp == OP_WRITE)
                  || (reqOp == OP_INV) || (reqOp == OP_RWIM);

    assign isRead  = (opReg == OP_READ);
    assign isWrite = (opReg == OP_WRITE);
    assign isInv   = (opReg == OP_INV);
    assign isRwim  = (opReg == OP_RWIM);

    assign sampleNow = (state == SNOOP_WAIT) && (waitCnt == 4'd1);
    assign goWb      = (snoopBusIn == SNP_HITM) && (isRead || isRwim);

    // A reserved snoop code on READ is treated as NOHIT.
    always_comb begin
        sampleMesi = MESI_I;
        unique case (1'b1)
            isRead: begin
                if (snoopBusIn == SNP_HIT || snoopBusIn == SNP_HITM) begin
                    sampleMesi = MESI_S;
                end else begin
                    sampleMesi = MESI_E;
                end
            end
            isRwim, isInv: sampleMesi = MESI_M;
            isWrite:       sampleMesi = MESI_I;
            default:       sampleMesi = MESI_I;
        endcase
    end

`ifdef SNOOP_WB_TIMEOUT_EN
    localparam int WbW = $clog2(wbTimeout + 1);
    localparam logic [WbW-1:0] WbLast = WbW'(wbTimeout - 1);

    logic [WbW-1:0] wbCnt;
    logic           errReg;
    logic           wbExpire;

    assign wbExpire  = (state == WB_WAIT) && (wbCnt == WbLast);
    assign respError = errReg;

    // wbDone on the limit cycle still completes the writeback normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbCnt  <= '0;
            errReg <= 1'b0;
        end else begin
            if (state == WB_WAIT) begin
                wbCnt <= wbCnt + WbW'(1);
            end else begin
                wbCnt <= '0;
            end
            if (accept) begin
                errReg <= 1'b0;
            end else if (wbExpire && !wbDone) begin
                errReg <= 1'b1;
            end
        end
    end
`else
    assign respError = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            opReg     <= '0;
            addrReg   <= '0;
            waitCnt   <= '0;
            resultReg <= 2'b00;
            mesiReg   <= MESI_I;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqValid) begin
                        opReg   <= reqOp;
                        addrReg <= reqAddr;
                        if (opLegal) begin
                            state   <= ISSUE;
                            waitCnt <= 4'(snoopWait);
                        end else begin
                            state     <= RESP;
                            resultReg <= SNP_BAD;
                            mesiReg   <= MESI_I;
                        end
                    end
                end
                ISSUE: begin
                    state <= SNOOP_WAIT;
                end
                SNOOP_WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (sampleNow) begin
                        resultReg <= snoopBusIn;
                        mesiReg   <= sampleMesi;
                        state     <= goWb ? WB_WAIT : RESP;
                    end
                end
                WB_WAIT: begin
                    if (wbDone) begin
                        state <= RESP;
`ifdef SNOOP_WB_TIMEOUT_EN
                    end else if (wbExpire) begin
                        state     <= RESP;
                        resultReg <= SNP_HITM;
                        mesiReg   <= MESI_I;
`endif
                    end
                end
                RESP: begin
                    if (respReady) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busOwned = (state == ISSUE) || (state == SNOOP_WAIT)
                   || (state == WB_WAIT);

    assign sharedBusOut          = busOwned ? lineSize'(addrReg) : '0;
    assign sharedOperationBusOut = busOwned ? opReg : 8'd0;

    assign reqReady   = (state == IDLE);
    assign respValid  = (state == RESP);
    assign respResult = resultReg;
    assign respMesi   = mesiReg;

endmodule

// File: tb/tb_snoop_bus_initiator.sv
// Bench for snoop_bus_initiator: directed and random transactions checked
// against a latency/state model derived from the bus protocol rules.
module tb_snoop_bus_initiator;

    localparam int LS  = 512;
    localparam int AW  = 32;
    localparam int SW  = 2;
    localparam int WBT = 16;
`ifdef SNOOP_WB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    typedef struct {
        int          respK;
        int          busCyc;
        logic [1:0]  res;
        logic [1:0]  mesi;
        logic        err;
    } exp_t;

    typedef struct {
        int          respK;
        int          busCyc;
        int          validCyc;
        logic [7:0]  busOp;
        logic [31:0] busAddr;
        logic [1:0]  res;
        logic [1:0]  mesi;
        logic        err;
        bit          dirty;
        bit          busInResp;
        bit          unstable;
        bit          readyBusy;
        bit          readyStart;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          reqValid = 1'b0;
    logic          reqReady;
    logic [7:0]    reqOp = 8'd0;
    logic [AW-1:0] reqAddr = '0;
    logic [LS-1:0] sharedBusOut;
    logic [7:0]    sharedOperationBusOut;
    logic [1:0]    snoopBusIn = 2'b00;
    logic          wbDone = 1'b0;
    logic          respValid;
    logic          respReady = 1'b0;
    logic [1:0]    respResult;
    logic [1:0]    respMesi;
    logic          respError;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snoop_bus_initiator #(
        .lineSize (LS),
        .addrWidth(AW),
        .snoopWait(SW),
        .wbTimeout(WBT)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .reqValid             (reqValid),
        .reqReady             (reqReady),
        .reqOp                (reqOp),
        .reqAddr              (reqAddr),
        .sharedBusOut         (sharedBusOut),
        .sharedOperationBusOut(sharedOperationBusOut),
        .snoopBusIn           (snoopBusIn),
        .wbDone               (wbDone),
        .respValid            (respValid),
        .respReady            (respReady),
        .respResult           (respResult),
        .respMesi             (respMesi),
        .respError            (respError)
    );

    // Cycle k counts negedges after the accept edge; -1 means never.
    function automatic exp_t model(input logic [7:0] op,
                                   input logic [1:0] snp,
                                   input int d);
        exp_t e;
        e.err = 1'b0;
        e.res = snp;
        if (op == 8'd0 || op > 8'd4) begin
            e.respK  = 0;
            e.busCyc = 0;
            e.res    = 2'b11;
            e.mesi   = 2'd0;
            return e;
        end
        if (op == 8'd1) e.mesi = (snp == 2'b01 || snp == 2'b10) ? 2'd1 : 2'd2;
        else if (op == 8'd2) e.mesi = 2'd0;
        else e.mesi = 2'd3;
        e.respK = SW + 1;
        if (snp == 2'b10 && (op == 8'd1 || op == 8'd4)) begin
            if (d >= 1 && (!TO || d <= WBT)) begin
                e.respK = SW + 1 + d;
            end else if (TO) begin
                e.respK = SW + 1 + WBT;
                e.err   = 1'b1;
                e.mesi  = 2'd0;
            end else begin
                e.respK = -1;
            end
        end
        e.busCyc = e.respK;
        return e;
    endfunction

    // Issues one request from IDLE at a negedge and records what the DUT does.
    task automatic run_txn(input logic [7:0] op, input logic [AW-1:0] addr,
                           input logic [1:0] snp, input int wbAt,
                           input int rDly, input bit noise, input int budget,
                           output obs_t o);
        o.respK = -1; o.busCyc = 0; o.validCyc = 0;
        o.busOp = 8'd0; o.busAddr = 32'd0;
        o.res = 2'b00; o.mesi = 2'b00; o.err = 1'b0;
        o.dirty = 0; o.busInResp = 0; o.unstable = 0; o.readyBusy = 0;
        o.readyStart = reqReady;
        reqValid = 1'b1; reqOp = op; reqAddr = addr;
        snoopBusIn = ~snp; wbDone = 1'b0; respReady = 1'b0;
        @(negedge clk);
        reqValid = 1'b0; reqOp = 8'd0; reqAddr = '0;
        for (int k = 0; k < budget; k++) begin
            if (o.respK >= 0 && !respValid) break;
            if (sharedOperationBusOut != 8'd0) begin
                o.busCyc++;
                o.busOp = sharedOperationBusOut;
                o.busAddr = sharedBusOut[AW-1:0];
                if (sharedBusOut[LS-1:AW] != '0) o.dirty = 1;
            end else if (sharedBusOut != '0) begin
                o.dirty = 1;
            end
            if (reqReady) o.readyBusy = 1;
            if (respValid) begin
                if (o.respK < 0) begin
                    o.respK = k;
                    o.res = respResult; o.mesi = respMesi; o.err = respError;
                end else if (respResult !== o.res || respMesi !== o.mesi
                             || respError !== o.err) begin
                    o.unstable = 1;
                end
                o.validCyc++;
                if (sharedOperationBusOut != 8'd0 || sharedBusOut != '0)
                    o.busInResp = 1;
                respReady = (k - o.respK >= rDly);
            end else begin
                respReady = 1'b0;
            end
            snoopBusIn = (k == SW) ? snp : ~snp;
            if (noise && k <= SW) wbDone = 1'($urandom_range(0, 1));
            else wbDone = (wbAt > 0 && k == SW + wbAt);
            @(negedge clk);
        end
        wbDone = 1'b0; respReady = 1'b0; snoopBusIn = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (sharedBusOut !== '0) $display("FAIL rst.bus got %0h want 0", sharedBusOut); else nPass++;
        nChecks++; if (sharedOperationBusOut !== 8'd0) $display("FAIL rst.op got %0d want 0", sharedOperationBusOut); else nPass++;
        nChecks++; if (reqReady !== 1'b1) $display("FAIL rst.reqReady got %b want 1", reqReady); else nPass++;
        nChecks++; if (respValid !== 1'b0) $display("FAIL rst.respValid got %b want 0", respValid); else nPass++;
        nChecks++; if (respResult !== 2'b00) $display("FAIL rst.result got %b want 00", respResult); else nPass++;
        nChecks++; if (respMesi !== 2'd0) $display("FAIL rst.mesi got %0d want 0", respMesi); else nPass++;
        nChecks++; if (respError !== 1'b0) $display("FAIL rst.error got %b want 0", respError); else nPass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_nohit();
        obs_t o;
        exp_t e;
        e = model(8'd1, 2'b00, 0);
        run_txn(8'd1, 32'h1000, 2'b00, 0, 0, 0, 20, o);
        nChecks++; if (o.respK !== e.respK) $display("FAIL rd.lat got %0d want %0d", o.respK, e.respK); else nPass++;
        nChecks++; if (o.busCyc !== 3) $display("FAIL rd.busCyc got %0d want 3", o.busCyc); else nPass++;
        nChecks++; if (o.busOp !== 8'd1) $display("FAIL rd.busOp got %0d want 1", o.busOp); else nPass++;
        nChecks++; if (o.busAddr !== 32'h1000) $display("FAIL rd.busAddr got %0h want 1000", o.busAddr); else nPass++;
        nChecks++; if (o.res !== 2'b00) $display("FAIL rd.result got %b want 00", o.res); else nPass++;
        nChecks++; if (o.mesi !== 2'd2) $display("FAIL rd.mesi got %0d want 2", o.mesi); else nPass++;
        nChecks++; if (o.validCyc !== 1) $display("FAIL rd.validCyc got %0d want 1", o.validCyc); else nPass++;
        nChecks++; if (o.dirty !== 1'b0) $display("FAIL rd.busUpper got %b want 0", o.dirty); else nPass++;
    endtask

    task automatic test_read_hitm();
        obs_t o;
        exp_t e;
        e = model(8'd1, 2'b10, 5);
        run_txn(8'd1, 32'h0000_4440, 2'b10, 5, 0, 1, 30, o);
        nChecks++; if (o.respK !== e.respK) $display("FAIL hitm.lat got %0d want %0d", o.respK, e.respK); else nPass++;
        nChecks++; if (o.busCyc !== e.busCyc) $display("FAIL hitm.busCyc got %0d want %0d", o.busCyc, e.busCyc); else nPass++;
        nChecks++; if (o.res !== 2'b10) $display("FAIL hitm.result got %b want 10", o.res); else nPass++;
        nChecks++; if (o.mesi !== 2'd1) $display("FAIL hitm.mesi got %0d want 1", o.mesi); else nPass++;
        nChecks++; if (o.busInResp !== 1'b0) $display("FAIL hitm.busInResp got %b want 0", o.busInResp); else nPass++;
        nChecks++; if (o.err !== 1'b0) $display("FAIL hitm.error got %b want 0", o.err); else nPass++;
    endtask

    task automatic test_ops();
        obs_t o;
        exp_t e;
        e = model(8'd4, 2'b01, 0);
        run_txn(8'd4, 32'h0000_8000, 2'b01, 0, 0, 0, 20, o);
        nChecks++; if (o.mesi !== e.mesi) $display("FAIL rwim.mesi got %0d want %0d", o.mesi, e.mesi); else nPass++;
        nChecks++; if (o.respK !== e.respK) $display("FAIL rwim.lat got %0d want %0d", o.respK, e.respK); else nPass++;
        e = model(8'd3, 2'b00, 0);
        run_txn(8'd3, 32'h0000_8040, 2'b00, 0, 0, 0, 20, o);
        nChecks++; if (o.mesi !== e.mesi) $display("FAIL inv.mesi got %0d want %0d", o.mesi, e.mesi); else nPass++;
        nChecks++; if (o.busOp !== 8'd3) $display("FAIL inv.busOp got %0d want 3", o.busOp); else nPass++;
        e = model(8'd2, 2'b10, 3);
        run_txn(8'd2, 32'h0000_8080, 2'b10, 3, 0, 0, 20, o);
        nChecks++; if (o.respK !== e.respK) $display("FAIL wr.lat got %0d want %0d", o.respK, e.respK); else nPass++;
        nChecks++; if (o.mesi !== e.mesi) $display("FAIL wr.mesi got %0d want %0d", o.mesi, e.mesi); else nPass++;
        nChecks++; if (o.res !== e.res) $display("FAIL wr.result got %b want %b", o.res, e.res); else nPass++;
    endtask

    task automatic test_illegal();
        obs_t o;
        exp_t e;
        e = model(8'h07, 2'b01, 0);
        run_txn(8'h07, 32'h0000_1234, 2'b01, 0, 0, 1, 20, o);
        nChecks++; if (o.respK !== e.respK) $display("FAIL ill.lat got %0d want %0d", o.respK, e.respK); else nPass++;
        nChecks++; if (o.busCyc !== 0) $display("FAIL ill.busCyc got %0d want 0", o.busCyc); else nPass++;
        nChecks++; if (o.res !== 2'b11) $display("FAIL ill.result got %b want 11", o.res); else nPass++;
        nChecks++; if (o.mesi !== 2'd0) $display("FAIL ill.mesi got %0d want 0", o.mesi); else nPass++;
        nChecks++; if (o.validCyc !== 1) $display("FAIL ill.validCyc got %0d want 1", o.validCyc); else nPass++;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        int seen;
        reqValid = 1'b1; reqOp = 8'd4; reqAddr = 32'hDEAD_BEE0;
        snoopBusIn = 2'b10; respReady = 1'b0;
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        nChecks++; if (sharedOperationBusOut !== 8'd4) $display("FAIL mid.busLive got %0d want 4", sharedOperationBusOut); else nPass++;
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (sharedBusOut !== '0) $display("FAIL mid.bus got %0h want 0", sharedBusOut[AW-1:0]); else nPass++;
        nChecks++; if (sharedOperationBusOut !== 8'd0) $display("FAIL mid.op got %0d want 0", sharedOperationBusOut); else nPass++;
        nChecks++; if (reqReady !== 1'b1) $display("FAIL mid.reqReady got %b want 1", reqReady); else nPass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (respValid) seen++;
            @(negedge clk);
        end
        nChecks++; if (seen !== 0) $display("FAIL mid.noResp got %0d want 0", seen); else nPass++;
        e = model(8'd3, 2'b01, 0);
        run_txn(8'd3, 32'h0000_2468, 2'b01, 0, 4, 0, 30, o);
        nChecks++; if (o.respK !== e.respK) $display("FAIL stall.lat got %0d want %0d", o.respK, e.respK); else nPass++;
        nChecks++; if (o.validCyc !== 5) $display("FAIL stall.validCyc got %0d want 5", o.validCyc); else nPass++;
        nChecks++; if (o.unstable !== 1'b0) $display("FAIL stall.stable got %b want 0", o.unstable); else nPass++;
        nChecks++; if (o.mesi !== e.mesi) $display("FAIL stall.mesi got %0d want %0d", o.mesi, e.mesi); else nPass++;
        nChecks++; if (o.res !== e.res) $display("FAIL stall.result got %b want %b", o.res, e.res); else nPass++;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int gap1;
        int gap2;
        reqOp = 8'd1; reqAddr = 32'h0000_3000;
        snoopBusIn = 2'b00; respReady = 1'b1; reqValid = 1'b1;
        for (int k = 0; k < 40 && acc.size() < 3; k++) begin
            if (reqReady) acc.push_back(cyc + 1);
            @(negedge clk);
        end
        reqValid = 1'b0;
        for (int k = 0; k < 20 && !reqReady; k++) @(negedge clk);
        respReady = 1'b0;
        gap1 = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
        gap2 = (acc.size() >= 3) ? acc[2] - acc[1] : -1;
        nChecks++; if (acc.size() !== 3) $display("FAIL b2b.accepts got %0d want 3", acc.size()); else nPass++;
        nChecks++; if (gap1 !== SW + 3) $display("FAIL b2b.gap1 got %0d want %0d", gap1, SW + 3); else nPass++;
        nChecks++; if (gap2 !== SW + 3) $display("FAIL b2b.gap2 got %0d want %0d", gap2, SW + 3); else nPass++;
        nChecks++; if (reqReady !== 1'b1) $display("FAIL b2b.idle got %b want 1", reqReady); else nPass++;
    endtask

    task automatic test_wb_watchdog();
        obs_t o;
        exp_t e;
        if (TO) begin
            e = model(8'd1, 2'b10, 0);
            run_txn(8'd1, 32'h0000_5000, 2'b10, 0, 0, 0, 60, o);
            nChecks++; if (o.respK !== e.respK) $display("FAIL wdog.lat got %0d want %0d", o.respK, e.respK); else nPass++;
            nChecks++; if (o.err !== 1'b1) $display("FAIL wdog.error got %b want 1", o.err); else nPass++;
            nChecks++; if (o.res !== 2'b10) $display("FAIL wdog.result got %b want 10", o.res); else nPass++;
            nChecks++; if (o.mesi !== 2'd0) $display("FAIL wdog.mesi got %0d want 0", o.mesi); else nPass++;
            e = model(8'd4, 2'b10, WBT);
            run_txn(8'd4, 32'h0000_5040, 2'b10, WBT, 0, 0, 60, o);
            nChecks++; if (o.respK !== e.respK) $display("FAIL wdogRace.lat got %0d want %0d", o.respK, e.respK); else nPass++;
            nChecks++; if (o.err !== 1'b0) $display("FAIL wdogRace.error got %b want 0", o.err); else nPass++;
            nChecks++; if (o.mesi !== e.mesi) $display("FAIL wdogRace.mesi got %0d want %0d", o.mesi, e.mesi); else nPass++;
        end else begin
            e = model(8'd1, 2'b10, 0);
            run_txn(8'd1, 32'h0000_5000, 2'b10, 0, 0, 0, 40, o);
            nChecks++; if (o.respK !== e.respK) $display("FAIL hang.lat got %0d want %0d", o.respK, e.respK); else nPass++;
            nChecks++; if (o.busCyc !== 40) $display("FAIL hang.busCyc got %0d want 40", o.busCyc); else nPass++;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            nChecks++; if (reqReady !== 1'b1) $display("FAIL hang.recover got %b want 1", reqReady); else nPass++;
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic [7:0] op;
        logic [AW-1:0] addr;
        logic [1:0] snp;
        int d;
        int rDly;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            if (r <= 3) op = 8'(r + 1);
            else if (r == 4) op = 8'($urandom_range(5, 255));
            else op = 8'd0;
            addr = $urandom;
            snp = 2'($urandom_range(0, 3));
            d = $urandom_range(1, 6);
            rDly = $urandom_range(0, 3);
            e = model(op, snp, d);
            run_txn(op, addr, snp, d, rDly, 1, 40, o);
            nChecks++; if (o.readyStart !== 1'b1) $display("FAIL rnd%0d.ready got %b want 1", i, o.readyStart); else nPass++;
            nChecks++; if (o.respK !== e.respK) $display("FAIL rnd%0d.lat op %0d snp %b got %0d want %0d", i, op, snp, o.respK, e.respK); else nPass++;
            nChecks++; if (o.res !== e.res) $display("FAIL rnd%0d.result got %b want %b", i, o.res, e.res); else nPass++;
            nChecks++; if (o.mesi !== e.mesi) $display("FAIL rnd%0d.mesi op %0d snp %b got %0d want %0d", i, op, snp, o.mesi, e.mesi); else nPass++;
            nChecks++; if (o.err !== e.err) $display("FAIL rnd%0d.error got %b want %b", i, o.err, e.err); else nPass++;
            nChecks++; if (o.busCyc !== e.busCyc) $display("FAIL rnd%0d.busCyc got %0d want %0d", i, o.busCyc, e.busCyc); else nPass++;
            nChecks++; if (o.busOp !== (e.busCyc > 0 ? op : 8'd0)) $display("FAIL rnd%0d.busOp got %0d want %0d", i, o.busOp, op); else nPass++;
            nChecks++; if (o.busAddr !== (e.busCyc > 0 ? addr : 32'd0)) $display("FAIL rnd%0d.busAddr got %0h want %0h", i, o.busAddr, addr); else nPass++;
            nChecks++; if (o.dirty !== 1'b0) $display("FAIL rnd%0d.busUpper got %b want 0", i, o.dirty); else nPass++;
            nChecks++; if (o.busInResp !== 1'b0) $display("FAIL rnd%0d.busInResp got %b want 0", i, o.busInResp); else nPass++;
            nChecks++; if (o.unstable !== 1'b0) $display("FAIL rnd%0d.stable got %b want 0", i, o.unstable); else nPass++;
            nChecks++; if (o.validCyc !== rDly + 1) $display("FAIL rnd%0d.validCyc got %0d want %0d", i, o.validCyc, rDly + 1); else nPass++;
            nChecks++; if (o.readyBusy !== 1'b0) $display("FAIL rnd%0d.readyBusy got %b want 0", i, o.readyBusy); else nPass++;
        end
    endtask

    initial begin
        test_reset();
        test_read_nohit();
        test_read_hitm();
        test_ops();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_wb_watchdog();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/snoop_bus_initiator.md
SNOOP_BUS_INITIATOR -- requirements
Module: snoop_bus_initiator

Interface
REQ-001 Parameters SHALL be: lineSize, default 512, shared bus width; addrWidth, default 32, request address width; snoopWait, default 2 (legal values 1..15), cycles from bus drive to snoop sample; wbTimeout, default 16, WB_WAIT watchdog limit.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqValid  input  1  cache controller has a bus operation pending.
REQ-005 reqReady  output  1  high only in IDLE.
REQ-006 reqOp  input  8  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM; all other codes illegal.
REQ-007 reqAddr  input  addrWidth  line address.
REQ-008 sharedBusOut  output  lineSize  {zeros, address}; all zeros when the bus is not owned.
REQ-009 sharedOperationBusOut  output  8  operation code; 0 (NOP) when the bus is not owned.
REQ-010 snoopBusIn  input  2  snoop response: 00 NOHIT, 01 HIT, 10 HITM, 11 reserved.
REQ-011 wbDone  input  1  single-cycle pulse: the HITM owner has completed its writeback.
REQ-012 respValid  output  1  result available.
REQ-013 respReady  input  1  controller accepts the result.
REQ-014 respResult  output  2  sampled snoop value; 11 for an illegal op.
REQ-015 respMesi  output  2  next line state: 0=I, 1=S, 2=E, 3=M.
REQ-016 respError  output  1  watchdog abort flag; tied 0 when SNOOP_WB_TIMEOUT_EN is undefined.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, SNOOP_WAIT, WB_WAIT and RESP.
REQ-018 In IDLE, reqValid&&reqReady SHALL latch reqOp and reqAddr.
  - Legal op: next state ISSUE.
  - Illegal op: next state RESP with respResult=11, respMesi=I; bus never driven.
REQ-019 ISSUE lasts one cycle; ISSUE, SNOOP_WAIT and WB_WAIT SHALL drive the latched address and op on the shared bus.
REQ-020 Wait counter:
  - Loaded with snoopWait on entry to ISSUE.
  - Decremented in SNOOP_WAIT.
  - snoopBusIn SHALL be sampled on the edge where the counter reaches 0 (accept at edge T -> sample at edge T+1+snoopWait).
REQ-021 Sampled HITM on READ or RWIM SHALL go to WB_WAIT; all other cases SHALL go to RESP.
REQ-022 WB_WAIT SHALL hold the bus and go to RESP on the edge where wbDone=1; a wbDone seen in any other state SHALL be ignored.
REQ-023 respMesi SHALL be computed at the sample edge:
  - READ: NOHIT->E, HIT->S, HITM->S, 11->E (treated as NOHIT).
  - RWIM: M.
  - INVALIDATE: M.
  - WRITE: I.
REQ-024 RESP:
  - Bus released.
  - respValid=1, and respResult, respMesi, respError SHALL hold stable until respValid&&respReady.
  - Return to IDLE on that edge; a new request SHALL NOT be accepted in the same cycle.
REQ-025 No-HITM latency: respValid SHALL first be high in the cycle after edge T+1+snoopWait; minimum request-to-request spacing is snoopWait+3 cycles.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for a clock edge, force:
  - state=IDLE, counters=0.
  - sharedBusOut=0, sharedOperationBusOut=0.
  - respValid=0, respResult=00, respMesi=I, respError=0.
  - reqReady=1.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction silently (no response); the first accept after deassertion SHALL be a fresh transaction.

Configuration
REQ-028 Macro SNOOP_WB_TIMEOUT_EN defined:
  - A counter SHALL count WB_WAIT cycles.
  - On reaching wbTimeout without wbDone: go to RESP with respError=1, respResult=10, respMesi=I.
  - wbDone arriving in the same cycle as the limit SHALL win (respError=0).
REQ-029 Macro SNOOP_WB_TIMEOUT_EN undefined: no watchdog logic; WB_WAIT SHALL wait indefinitely; respError=0.

Verification
REQ-030 READ 0x1000, snoopWait=2, snoopBusIn=00, respReady=1 -> bus shows op 1 / address 0x1000 for 3 cycles; respResult=00, respMesi=E; respValid high exactly one cycle.
REQ-031 READ, snoopBusIn=10, wbDone pulses 5 cycles after the sample -> bus held through the pulse; respResult=10, respMesi=S; bus zero in RESP.
REQ-032 RWIM with HIT; then INVALIDATE with NOHIT -> respMesi=M both; WRITE with HITM -> no WB_WAIT, respMesi=I.
REQ-033 reqOp=0x07 -> no bus activity; respValid at the edge after accept; respResult=11, respMesi=I.
REQ-034 rst_n low during SNOOP_WAIT, respReady held low across RESP -> bus cleared asynchronously, no respValid; respValid and outputs stable until respReady.
REQ-035 With SNOOP_WB_TIMEOUT_EN, wbTimeout=16, HITM and no wbDone -> respError=1 sixteen cycles after entering WB_WAIT; repeat with wbDone on cycle 16 -> respError=0.
